// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule FSM states, rcon and the S-box.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  // Entry b sits (255-b) bytes up from bit 0, and 255-b is simply ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Round constant byte for rounds 1..10; zero elsewhere.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_subword (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  import aes_pkg::*;

  // Substitute each byte of the word independently.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule for decryption: expands forward to round 10, then
// walks the schedule backwards, handing out round keys 10 down to 0.
module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         key_ready_q, key_ready_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  prevW1, prevW2, prevW3;
  logic [31:0]  subIn, subOut, rconWord;
  logic [31:0]  fwdW0, fwdW1, fwdW2, fwdW3, prevW0;
  logic [3:0]   rconIdx;

  // One SubWord serves both directions; its input is already rotated.
  aes_subword u_subword (
    .word_i (subIn),
    .word_o (subOut)
  );

  // Forward and backward key steps sharing the single S-box path.
  always_comb begin
    w0 = key_q[127:96];
    w1 = key_q[95:64];
    w2 = key_q[63:32];
    w3 = key_q[31:0];

    prevW3 = w3 ^ w2;
    prevW2 = w2 ^ w1;
    prevW1 = w1 ^ w0;

    subIn    = (state_q == EMIT) ? {prevW3[23:0], prevW3[31:24]}
                                 : {w3[23:0], w3[31:24]};
    rconIdx  = (state_q == EMIT) ? rnd_q : rnd_q + 4'd1;
    rconWord = {rcon(rconIdx), 24'h000000};

    fwdW0  = w0 ^ subOut ^ rconWord;
    fwdW1  = w1 ^ fwdW0;
    fwdW2  = w2 ^ fwdW1;
    fwdW3  = w3 ^ fwdW2;
    prevW0 = w0 ^ subOut ^ rconWord;
  end

  // Next-state logic: accept a key, expand to round 10, then emit in reverse.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (key_valid && key_ready_q) begin
          key_d   = key_in;
          rnd_d   = 4'd0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        key_d = {fwdW0, fwdW1, fwdW2, fwdW3};
        rnd_d = rnd_q + 4'd1;
        if (rnd_q + 4'd1 == LAST_ROUND) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (rnd_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            key_d = {prevW0, prevW1, prevW2, prevW3};
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    key_ready_d = (state_d == IDLE);
  end

  // State, key register, round counter and the registered key_ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      rnd_q       <= '0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      rnd_q       <= rnd_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign key_ready = key_ready_q;
  assign rk_out    = key_q;
  assign rk_round  = rnd_q;
  assign rk_valid  = (state_q == EMIT);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched using known AES-128 round keys.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  localparam logic [127:0] ALT_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [127:0]        key;
    logic [10:0][127:0]  rk;
  } seq_t;

  seq_t seqs [2];

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;
  int t0, t1, tDummy;

  aes_inv_key_sched #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Cycle counter used to time key-to-key intervals.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Offer a key from a negedge and return once it has been accepted.
  task automatic applyStimulus(input logic [127:0] key, input bit keepValid,
                               output int acceptTime);
    int n = 0;
    key_in    = key;
    key_valid = 1'b1;
    while (key_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", 128'(n < 100), 128'(1));
    @(posedge clk);
    @(negedge clk);
    acceptTime = cycleCount;
    if (!keepValid) key_valid = 1'b0;
    checkOutput("key_ready_drop", 128'(key_ready), 128'(0));
    checkOutput("busy_after_accept", 128'(busy), 128'(1));
  endtask

  // Count cycles from acceptance to rk_valid, optionally pulsing a foreign key.
  task automatic waitLatency(input bit inject);
    int lat = 0;
    while (rk_valid !== 1'b1 && lat < 50) begin
      if (inject) begin
        key_valid = (lat == 3);
        key_in    = ALT_KEY;
      end
      @(negedge clk);
      lat++;
    end
    if (inject) key_valid = 1'b0;
    checkOutput("expand_latency", 128'(lat), 128'(10));
  endtask

  // Walk the emitted keys 10..0 against the table; stopRound < 0 runs to the end.
  task automatic emitSequence(input int s, input bit stalls, input bit inject,
                              input int stopRound);
    int r     = 10;
    int guard = 0;
    bit ready;
    while (r >= 0 && guard < 400) begin
      guard++;
      checkOutput($sformatf("rk_valid r%0d", r), 128'(rk_valid), 128'(1));
      checkOutput($sformatf("rk_round r%0d", r), 128'(rk_round), 128'(r));
      checkOutput($sformatf("rk_out s%0d r%0d", s, r), rk_out, seqs[s].rk[r]);
      if (r == stopRound) break;
      ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject) begin
        key_valid = (r == 6);
        key_in    = ALT_KEY;
      end
      rk_ready = ready;
      @(posedge clk);
      @(negedge clk);
      if (ready) r--;
    end
    rk_ready = 1'b0;
    if (inject) key_valid = 1'b0;
    checkOutput("emit_guard", 128'(guard < 400), 128'(1));
    if (stopRound < 0) begin
      checkOutput("key_ready_after_r0", 128'(key_ready), 128'(1));
      checkOutput("rk_valid_after_r0", 128'(rk_valid), 128'(0));
      checkOutput("busy_after_r0", 128'(busy), 128'(0));
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b0;

    seqs[0].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    seqs[0].rk  = {128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                   128'hac7766f319fadc2128d12941575c006e,
                   128'head27321b58dbad2312bf5607f8d292f,
                   128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                   128'h6d88a37a110b3efddbf98641ca0093fd,
                   128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                   128'hef44a541a8525b7fb671253bdb0bad00,
                   128'h3d80477d4716fe3e1e237e446d7a883b,
                   128'hf2c295f27a96b9435935807a7359f67f,
                   128'ha0fafe1788542cb123a339392a6c7605,
                   128'h2b7e151628aed2a6abf7158809cf4f3c};
    seqs[1].key = 128'h0;
    seqs[1].rk  = {128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                   128'hb1d4d8e28a7db9da1d7bb3de4c664941,
                   128'h0ef903333ba9613897060a04511dfa9f,
                   128'h217517873550620bacaf6b3cc61bf09b,
                   128'hec614b851425758c99ff09376ab49ba7,
                   128'h7f2e2b88f8443e098dda7cbbf34b9290,
                   128'hee06da7b876a1581759e42b27e91ee2b,
                   128'h90973450696ccffaf2f457330b0fac99,
                   128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
                   128'h62636363626363636263636362636363,
                   128'h00000000000000000000000000000000};

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_key_ready", 128'(key_ready), 128'(0));
    checkOutput("reset_rk_valid", 128'(rk_valid), 128'(0));
    checkOutput("reset_rk_out", rk_out, 128'h0);
    checkOutput("reset_rk_round", 128'(rk_round), 128'(0));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_key_ready", 128'(key_ready), 128'(1));
    checkOutput("post_reset_busy", 128'(busy), 128'(0));

    // Table-driven full runs with rk_ready already high before rk_valid.
    for (int s = 0; s < 2; s++) begin
      rk_ready = 1'b1;
      applyStimulus(seqs[s].key, 1'b0, tDummy);
      waitLatency(1'b0);
      emitSequence(s, 1'b0, 1'b0, -1);
    end

    // Random back-pressure on the FIPS key.
    applyStimulus(seqs[0].key, 1'b0, tDummy);
    waitLatency(1'b0);
    emitSequence(0, 1'b1, 1'b0, -1);

    // Foreign key pulsed during EXPAND and EMIT must be ignored.
    applyStimulus(seqs[0].key, 1'b0, tDummy);
    waitLatency(1'b1);
    emitSequence(0, 1'b0, 1'b1, -1);
    @(negedge clk);
    checkOutput("ignored_key_idle", 128'(busy), 128'(0));

    // Reset while round 5 is on the output.
    applyStimulus(seqs[0].key, 1'b0, tDummy);
    waitLatency(1'b0);
    emitSequence(0, 1'b0, 1'b0, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_rk_valid", 128'(rk_valid), 128'(0));
    checkOutput("midrst_busy", 128'(busy), 128'(0));
    checkOutput("midrst_key_ready", 128'(key_ready), 128'(0));
    checkOutput("midrst_rk_out", rk_out, 128'h0);
    checkOutput("midrst_rk_round", 128'(rk_round), 128'(0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_key_ready_held", 128'(key_ready), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_release_key_ready", 128'(key_ready), 128'(1));
    checkOutput("midrst_release_rk_valid", 128'(rk_valid), 128'(0));
    applyStimulus(seqs[0].key, 1'b0, tDummy);
    waitLatency(1'b0);
    emitSequence(0, 1'b0, 1'b0, -1);

    // Back-to-back keys with key_valid held throughout.
    applyStimulus(seqs[0].key, 1'b1, t0);
    key_in = seqs[1].key;
    waitLatency(1'b0);
    emitSequence(0, 1'b0, 1'b0, -1);
    applyStimulus(seqs[1].key, 1'b0, t1);
    checkOutput("key_to_key_interval", 128'(t1 - t0), 128'(22));
    waitLatency(1'b0);
    emitSequence(1, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
